// File: rtl/circuito_projeto_pkg.sv
// circuito_projeto_pkg
// Shared definitions for the water-level control unit:
//   - estado_t      : 4-bit Moore state encoding (15 states, INICIAL=0 .. ERRO=14)
//   - CLASSE_*      : classifier codes that select a buzzer
//   - MAX_DESCARTES_DEF : default number of consecutive discards before ERRO
package circuito_projeto_pkg;

  typedef enum logic [3:0] {
    INICIAL         = 4'd0,
    PREPARA         = 4'd1,
    ESPERA_1S       = 4'd2,
    MEDE            = 4'd3,
    AGUARDA_MEDIDA  = 4'd4,
    CLASSIFICA      = 4'd5,
    AGUARDA_CLASSIF = 4'd6,
    DESCARTE        = 4'd7,
    ENVIA           = 4'd8,
    AGUARDA_CARATER = 4'd9,
    MUDA            = 4'd10,
    ALARME          = 4'd11,
    ESPERA_2S       = 4'd12,
    DESLIGA         = 4'd13,
    ERRO            = 4'd14
  } estado_t;

  localparam logic [2:0] CLASSE_BAIXA = 3'b001;
  localparam logic [2:0] CLASSE_ALTA  = 3'b100;

  localparam int MAX_DESCARTES_DEF = 3;

endpackage

// File: rtl/circuito_projeto_uc_if.sv
// circuito_projeto_uc_if
// Control/status bundle between the control unit and the measurement datapath.
//   master : control unit (drives controls, reads status)
//   slave  : datapath     (reads controls, drives status)
interface circuito_projeto_uc_if;

  // datapath status
  logic       fim_medida;
  logic       fim_carater;
  logic       fim_mensagem;
  logic       fim_classificacao;
  logic       fim_1s;
  logic       fim_2s;
  logic [2:0] medida_classificacao;
  logic       descartar_medida;

  // datapath and buzzer controls
  logic       zera;
  logic       conta_1s;
  logic       conta_2s;
  logic       mensurar;
  logic       envia;
  logic       muda;
  logic       analisa_medida;
  logic       liga_buzzer_baixa;
  logic       liga_buzzer_alta;
  logic       desliga_buzzers;
  logic       zera_vlv;

  modport master (
    input  fim_medida, fim_carater, fim_mensagem, fim_classificacao, fim_1s, fim_2s,
           medida_classificacao, descartar_medida,
    output zera, conta_1s, conta_2s, mensurar, envia, muda, analisa_medida,
           liga_buzzer_baixa, liga_buzzer_alta, desliga_buzzers, zera_vlv
  );

  modport slave (
    output fim_medida, fim_carater, fim_mensagem, fim_classificacao, fim_1s, fim_2s,
           medida_classificacao, descartar_medida,
    input  zera, conta_1s, conta_2s, mensurar, envia, muda, analisa_medida,
           liga_buzzer_baixa, liga_buzzer_alta, desliga_buzzers, zera_vlv
  );

endinterface

// File: rtl/circuito_projeto_uc_contador_m.sv
// contador_m
// N-bit up counter that saturates at M.
//   clock : clock
//   reset : synchronous active-high clear
//   zera  : synchronous clear
//   conta : increment enable (ignored once q reaches M)
//   q     : current count
module contador_m #(
  parameter int M = 3,
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // next count: clear wins over increment, hold at M
  always_comb begin
    q_d = q_q;
    if (zera) begin
      q_d = {N{1'b0}};
    end else if (conta && (q_q != N'(M))) begin
      q_d = q_q + {{(N-1){1'b0}}, 1'b1};
    end else begin
      q_d = q_q;
    end
  end

  // count register
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= {N{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/circuito_projeto_uc.sv
// circuito_projeto_uc
// Moore control unit sequencing settle / measure / classify / report / buzzer / pause.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   ligar        : run request (level)
//   dp           : datapath bundle (master side)
//   pronto       : one-cycle pulse per completed report cycle
//   erro         : high while in ERRO
//   db_estado    : raw state encoding, only when CIRCUITO_UC_DB_ESTADO_EN is defined
module circuito_projeto_uc
  import circuito_projeto_pkg::*;
#(
  parameter int MAX_DESCARTES = MAX_DESCARTES_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ligar,
  circuito_projeto_uc_if.master  dp,
  output logic                   pronto,
  output logic                   erro
`ifdef CIRCUITO_UC_DB_ESTADO_EN
  ,
  output logic [3:0]             db_estado
`endif
);

  estado_t    estado_q;
  estado_t    estado_d;
  logic [2:0] classe_q;
  logic [2:0] desc_q;
  logic       zera_desc_s;
  logic       conta_desc_s;

  // consecutive-discard counter, cleared on PREPARA and on every accepted report
  contador_m #(
    .M (MAX_DESCARTES),
    .N (3)
  ) u_contador_descartes (
    .clock (clock),
    .reset (reset),
    .zera  (zera_desc_s),
    .conta (conta_desc_s),
    .q     (desc_q)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  // class latched when the classifier finishes; selects the buzzer in ALARME
  always_ff @(posedge clock) begin
    if (reset) begin
      classe_q <= 3'b000;
    end else if ((estado_q == AGUARDA_CLASSIF) && dp.fim_classificacao) begin
      classe_q <= dp.medida_classificacao;
    end else begin
      classe_q <= classe_q;
    end
  end

  // next-state and Moore output decode
  always_comb begin
    estado_d             = estado_q;
    dp.zera              = 1'b0;
    dp.conta_1s          = 1'b0;
    dp.conta_2s          = 1'b0;
    dp.mensurar          = 1'b0;
    dp.envia             = 1'b0;
    dp.muda              = 1'b0;
    dp.analisa_medida    = 1'b0;
    dp.liga_buzzer_baixa = 1'b0;
    dp.liga_buzzer_alta  = 1'b0;
    dp.desliga_buzzers   = 1'b0;
    dp.zera_vlv          = 1'b0;
    pronto               = 1'b0;
    erro                 = 1'b0;
    zera_desc_s          = 1'b0;
    conta_desc_s         = 1'b0;

    case (estado_q)
      INICIAL: begin
        estado_d = ligar ? PREPARA : INICIAL;
      end
      PREPARA: begin
        dp.zera     = 1'b1;
        dp.zera_vlv = 1'b1;
        zera_desc_s = 1'b1;
        estado_d    = ESPERA_1S;
      end
      ESPERA_1S: begin
        dp.conta_1s = 1'b1;
        // stop request has priority over the timer
        if (!ligar) begin
          estado_d = DESLIGA;
        end else if (dp.fim_1s) begin
          estado_d = MEDE;
        end else begin
          estado_d = ESPERA_1S;
        end
      end
      MEDE: begin
        dp.mensurar = 1'b1;
        estado_d    = AGUARDA_MEDIDA;
      end
      AGUARDA_MEDIDA: begin
        estado_d = dp.fim_medida ? CLASSIFICA : AGUARDA_MEDIDA;
      end
      CLASSIFICA: begin
        dp.analisa_medida = 1'b1;
        estado_d          = AGUARDA_CLASSIF;
      end
      AGUARDA_CLASSIF: begin
        if (dp.fim_classificacao) begin
          estado_d = dp.descartar_medida ? DESCARTE : ENVIA;
        end else begin
          estado_d = AGUARDA_CLASSIF;
        end
      end
      DESCARTE: begin
        conta_desc_s = 1'b1;
        // compare against the value the counter takes on this edge
        if ((desc_q + 3'd1) == 3'(MAX_DESCARTES)) begin
          estado_d = ERRO;
        end else begin
          estado_d = MEDE;
        end
      end
      ENVIA: begin
        dp.envia    = 1'b1;
        zera_desc_s = 1'b1;
        estado_d    = AGUARDA_CARATER;
      end
      AGUARDA_CARATER: begin
        estado_d = dp.fim_carater ? MUDA : AGUARDA_CARATER;
      end
      MUDA: begin
        dp.muda  = 1'b1;
        estado_d = dp.fim_mensagem ? ALARME : ENVIA;
      end
      ALARME: begin
        pronto = 1'b1;
        case (classe_q)
          CLASSE_BAIXA: dp.liga_buzzer_baixa = 1'b1;
          CLASSE_ALTA:  dp.liga_buzzer_alta  = 1'b1;
          default:      dp.desliga_buzzers   = 1'b1;
        endcase
        estado_d = ESPERA_2S;
      end
      ESPERA_2S: begin
        dp.conta_2s = 1'b1;
        if (!ligar) begin
          estado_d = DESLIGA;
        end else if (dp.fim_2s) begin
          estado_d = MEDE;
        end else begin
          estado_d = ESPERA_2S;
        end
      end
      DESLIGA: begin
        dp.desliga_buzzers = 1'b1;
        dp.zera_vlv        = 1'b1;
        estado_d           = INICIAL;
      end
      ERRO: begin
        erro               = 1'b1;
        dp.desliga_buzzers = 1'b1;
        estado_d           = ligar ? ERRO : INICIAL;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase
  end

`ifdef CIRCUITO_UC_DB_ESTADO_EN
  assign db_estado = estado_q;
`endif

endmodule

// File: tb/tb_circuito_projeto_uc.sv
// tb_circuito_projeto_uc
// Directed bench for circuito_projeto_uc: every cycle the packed output vector is
// compared against the hand-derived Moore output of the expected state.
module tb_circuito_projeto_uc;

  // output vector bit order:
  // {zera, conta_1s, conta_2s, mensurar, envia, muda, analisa_medida,
  //  liga_buzzer_baixa, liga_buzzer_alta, desliga_buzzers, zera_vlv, pronto, erro}
  localparam logic [15:0] O_NONE     = 16'h0000;
  localparam logic [15:0] O_PREP     = 16'h1004;
  localparam logic [15:0] O_E1S      = 16'h0800;
  localparam logic [15:0] O_E2S      = 16'h0400;
  localparam logic [15:0] O_MEDE     = 16'h0200;
  localparam logic [15:0] O_ENV      = 16'h0100;
  localparam logic [15:0] O_MUDA     = 16'h0080;
  localparam logic [15:0] O_CLAS     = 16'h0040;
  localparam logic [15:0] O_AL_BAIXA = 16'h0022;
  localparam logic [15:0] O_AL_ALTA  = 16'h0012;
  localparam logic [15:0] O_AL_DESL  = 16'h000A;
  localparam logic [15:0] O_DESLIGA  = 16'h000C;
  localparam logic [15:0] O_ERRO     = 16'h0009;

  logic clock = 1'b0;
  logic reset;
  logic ligar;
  logic pronto;
  logic erro;
`ifdef CIRCUITO_UC_DB_ESTADO_EN
  logic [3:0] db_estado;
`endif

  circuito_projeto_uc_if dp ();

  circuito_projeto_uc #(.MAX_DESCARTES(3)) dut (
    .clock  (clock),
    .reset  (reset),
    .ligar  (ligar),
    .dp     (dp.master),
    .pronto (pronto),
    .erro   (erro)
`ifdef CIRCUITO_UC_DB_ESTADO_EN
    ,
    .db_estado (db_estado)
`endif
  );

  always #5 clock = ~clock;

  logic [15:0] outs;
  assign outs = {3'b000, dp.zera, dp.conta_1s, dp.conta_2s, dp.mensurar, dp.envia, dp.muda,
                 dp.analisa_medida, dp.liga_buzzer_baixa, dp.liga_buzzer_alta,
                 dp.desliga_buzzers, dp.zera_vlv, pronto, erro};

  int n_total = 0;
  int n_bad   = 0;
  int mens_cnt  = 0;
  int envia_cnt = 0;
  int mark;

  always @(posedge clock) begin
    if (dp.mensurar === 1'b1) mens_cnt  <= mens_cnt + 1;
    if (dp.envia === 1'b1)    envia_cnt <= envia_cnt + 1;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // starts in MEDE; ends in ENVIA (accepted) or DESCARTE (rejected)
  task automatic measure(input logic [2:0] cl, input logic desc);
    cyc(); chk("aguarda_medida", outs, O_NONE);
    cyc(); chk("aguarda_medida_hold", outs, O_NONE);
    dp.fim_medida = 1'b1;
    cyc(); dp.fim_medida = 1'b0; chk("classifica", outs, O_CLAS);
    cyc(); chk("aguarda_classif", outs, O_NONE);
    dp.medida_classificacao = cl;
    dp.descartar_medida     = desc;
    dp.fim_classificacao    = 1'b1;
    cyc();
    dp.fim_classificacao = 1'b0;
    dp.descartar_medida  = 1'b0;
    dp.medida_classificacao = 3'b000;
    if (desc) chk("descarte", outs, O_NONE);
    else      chk("envia", outs, O_ENV);
  endtask

  // starts in ENVIA; ends in ESPERA_2S
  task automatic report(input logic [15:0] alarm);
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("aguarda_carater", outs, O_NONE);
      dp.fim_carater = 1'b1;
      cyc(); dp.fim_carater = 1'b0; chk("muda", outs, O_MUDA);
      if (i == 3) dp.fim_mensagem = 1'b1;
      cyc(); dp.fim_mensagem = 1'b0;
      if (i == 3) chk("alarme", outs, alarm);
      else        chk("envia_next", outs, O_ENV);
    end
    cyc(); chk("espera_2s", outs, O_E2S);
  endtask

  // bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ligar = 1'b0;
    dp.fim_medida = 1'b0; dp.fim_carater = 1'b0; dp.fim_mensagem = 1'b0;
    dp.fim_classificacao = 1'b0; dp.fim_1s = 1'b0; dp.fim_2s = 1'b0;
    dp.medida_classificacao = 3'b000; dp.descartar_medida = 1'b0;

    // reset state
    cyc(); cyc();
    chk("reset_outs", outs, O_NONE);
    reset = 1'b0;

    // start: PREPARA, settle, fim_1s at cycle 10
    ligar = 1'b1;
    cyc(); chk("prepara", outs, O_PREP);
    cyc(); chk("espera_1s", outs, O_E1S);
    for (int k = 0; k < 8; k++) begin
      cyc(); chk("espera_1s_hold", outs, O_E1S);
    end
    dp.fim_1s = 1'b1;
    cyc(); dp.fim_1s = 1'b0; chk("mede_after_1s", outs, O_MEDE);

    // class 001, four characters, low buzzer with pronto
    mark = envia_cnt;
    measure(3'b001, 1'b0);
    report(O_AL_BAIXA);
    n_total++;
    assert (envia_cnt - mark == 4) else begin
      n_bad++; $error("FAIL envia_count observed=%0d expected=4", envia_cnt - mark);
    end

    // ligar ignored in the middle of a measurement
    dp.fim_2s = 1'b1;
    cyc(); dp.fim_2s = 1'b0; chk("mede_after_2s", outs, O_MEDE);
    ligar = 1'b0;
    cyc(); chk("ligar_ignored", outs, O_NONE);
    ligar = 1'b1;
    dp.fim_medida = 1'b1;
    cyc(); dp.fim_medida = 1'b0; chk("classifica_b", outs, O_CLAS);
    cyc(); chk("aguarda_classif_b", outs, O_NONE);
    dp.medida_classificacao = 3'b100; dp.fim_classificacao = 1'b1;
    cyc(); dp.fim_classificacao = 1'b0; dp.medida_classificacao = 3'b000;
    chk("envia_b", outs, O_ENV);
    report(O_AL_ALTA);

    // class 010 -> buzzers off
    dp.fim_2s = 1'b1;
    cyc(); dp.fim_2s = 1'b0; chk("mede_c", outs, O_MEDE);
    measure(3'b010, 1'b0);
    report(O_AL_DESL);

    // three consecutive discards -> ERRO
    mark = mens_cnt;
    dp.fim_2s = 1'b1;
    cyc(); dp.fim_2s = 1'b0; chk("mede_d1", outs, O_MEDE);
    measure(3'b001, 1'b1);
    cyc(); chk("mede_d2", outs, O_MEDE);
    measure(3'b001, 1'b1);
    cyc(); chk("mede_d3", outs, O_MEDE);
    measure(3'b001, 1'b1);
    cyc(); chk("erro", outs, O_ERRO);
    n_total++;
    assert (mens_cnt - mark == 3) else begin
      n_bad++; $error("FAIL mensurar_count observed=%0d expected=3", mens_cnt - mark);
    end
    cyc(); chk("erro_hold", outs, O_ERRO);
    ligar = 1'b0;
    cyc(); chk("erro_exit", outs, O_NONE);

    // two discards, then a valid one clears the counter; three more -> ERRO
    ligar = 1'b1;
    cyc(); chk("prepara_2", outs, O_PREP);
    cyc(); chk("espera_1s_2", outs, O_E1S);
    dp.fim_1s = 1'b1;
    cyc(); dp.fim_1s = 1'b0; chk("mede_e1", outs, O_MEDE);
    measure(3'b001, 1'b1);
    cyc(); chk("mede_e2", outs, O_MEDE);
    measure(3'b001, 1'b1);
    cyc(); chk("mede_e3", outs, O_MEDE);
    measure(3'b000, 1'b0);
    report(O_AL_DESL);
    dp.fim_2s = 1'b1;
    cyc(); dp.fim_2s = 1'b0; chk("mede_f1", outs, O_MEDE);
    measure(3'b001, 1'b1);
    cyc(); chk("mede_f2_no_erro", outs, O_MEDE);
    measure(3'b001, 1'b1);
    cyc(); chk("mede_f3_no_erro", outs, O_MEDE);
    measure(3'b001, 1'b1);
    cyc(); chk("erro_2", outs, O_ERRO);
    ligar = 1'b0;
    cyc(); chk("erro_exit_2", outs, O_NONE);

    // ligar=0 together with fim_2s -> DESLIGA, no mensurar
    ligar = 1'b1;
    cyc(); chk("prepara_3", outs, O_PREP);
    cyc(); chk("espera_1s_3", outs, O_E1S);
    dp.fim_1s = 1'b1;
    cyc(); dp.fim_1s = 1'b0; chk("mede_g", outs, O_MEDE);
    measure(3'b001, 1'b0);
    report(O_AL_BAIXA);
    mark = mens_cnt;
    ligar = 1'b0; dp.fim_2s = 1'b1;
    cyc(); dp.fim_2s = 1'b0; chk("desliga", outs, O_DESLIGA);
    cyc(); chk("inicial_after_desliga", outs, O_NONE);
    n_total++;
    assert (mens_cnt == mark) else begin
      n_bad++; $error("FAIL no_mensurar observed=%0d expected=%0d", mens_cnt, mark);
    end

    // reset during AGUARDA_CARATER aborts at once
    ligar = 1'b1;
    cyc(); chk("prepara_4", outs, O_PREP);
    cyc(); chk("espera_1s_4", outs, O_E1S);
    dp.fim_1s = 1'b1;
    cyc(); dp.fim_1s = 1'b0; chk("mede_h", outs, O_MEDE);
    measure(3'b100, 1'b0);
    cyc(); chk("aguarda_carater_h", outs, O_NONE);
    reset = 1'b1;
    cyc(); chk("reset_abort", outs, O_NONE);
    reset = 1'b0; ligar = 1'b0;
    cyc(); chk("idle_after_reset", outs, O_NONE);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/circuito_projeto_uc.md
# circuito_projeto_uc

Control unit that sequences the water-level measurement datapath. It runs a fixed cycle: reset, 1 s settle, triple-sensor measure, classification, discard/retry, 4-character serial report, buzzer update and 2 s pause. It drives every control input of the datapath from a single Moore FSM and consumes its `fim_*`/classification status. It sits between the top-level user inputs and the datapath.

## Interface
- `MAX_DESCARTES`, 3: consecutive discarded measurements tolerated before entering ERRO (1..7).
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high; forces INICIAL and clears all registers.
- `ligar` in 1: level; 1 = run the monitoring cycle, 0 = stop at the next wait point.
- `fim_medida`, `fim_carater`, `fim_mensagem`, `fim_classificacao`, `fim_1s`, `fim_2s` in 1 each: datapath status.
- `medida_classificacao` in 3: class code from the classifier.
- `descartar_medida` in 1: classifier rejects the current measurement.
- `zera`, `conta_1s`, `conta_2s`, `mensurar`, `envia`, `muda`, `analisa_medida` out 1 each: datapath controls.
- `liga_buzzer_baixa`, `liga_buzzer_alta`, `desliga_buzzers`, `zera_vlv` out 1 each: buzzer controls.
- `pronto` out 1: one-cycle pulse per completed report cycle.
- `erro` out 1: level; high while in ERRO.

## Operation
- Moore FSM. All outputs decode from the state register. Every output is 0 in any state not listed below.
- INICIAL: if `ligar`=1, go to PREPARA.
- PREPARA: `zera`=1, `zera_vlv`=1. Clear the discard counter. Go to ESPERA_1S.
- ESPERA_1S: `conta_1s`=1.
  - `ligar`=0 → DESLIGA.
  - else `fim_1s` → MEDE.
- MEDE: `mensurar`=1 for one cycle. Go to AGUARDA_MEDIDA.
- AGUARDA_MEDIDA: wait for `fim_medida` → CLASSIFICA.
- CLASSIFICA: `analisa_medida`=1 for one cycle. Go to AGUARDA_CLASSIF.
- AGUARDA_CLASSIF: on `fim_classificacao`, latch `medida_classificacao` into `classe_reg`.
  - `descartar_medida`=1 → DESCARTE.
  - else → ENVIA.
- DESCARTE: increment the discard counter.
  - If the new value equals `MAX_DESCARTES` → ERRO.
  - else → MEDE.
- ENVIA: `envia`=1 for one cycle. Clear the discard counter. Go to AGUARDA_CARATER.
- AGUARDA_CARATER: wait for `fim_carater` → MUDA.
- MUDA: `muda`=1 for one cycle.
  - `fim_mensagem`=1 (last of 4 chars just sent; the selector wraps to 0) → ALARME.
  - else → ENVIA.
- ALARME: `pronto`=1 for one cycle. The buzzer output depends on `classe_reg`:
  - 3'b001 → `liga_buzzer_baixa`=1.
  - 3'b100 → `liga_buzzer_alta`=1.
  - any other code → `desliga_buzzers`=1.
  - Go to ESPERA_2S.
- ESPERA_2S: `conta_2s`=1.
  - `ligar`=0 → DESLIGA.
  - else `fim_2s` → MEDE.
- DESLIGA: `desliga_buzzers`=1, `zera_vlv`=1. Go to INICIAL.
- ERRO: `erro`=1, `desliga_buzzers`=1.
  - `ligar`=0 → INICIAL.
  - Otherwise stay; there is no automatic recovery.
- `ligar` is ignored outside INICIAL, ESPERA_1S, ESPERA_2S and ERRO. An in-flight measurement or report always completes.
- Discard counter width is 3 bits. It never exceeds `MAX_DESCARTES`.

## Timing
- Reset: state=INICIAL, `classe_reg`=0, discard counter=0. Therefore every output is 0 one cycle after `reset` is sampled high. `reset` mid-operation aborts immediately, with no DESLIGA pass.
- Single-cycle strobes (`mensurar`, `analisa_medida`, `envia`, `muda`, `zera`, `pronto`, buzzer commands) are high for exactly one clock.
- A status input is acted on in the cycle it is sampled high. The next state is entered on the following edge, so the response strobe appears 1 cycle after the status.
- Simultaneous `ligar`=0 and `fim_1s`/`fim_2s`: `ligar`=0 wins.
- Minimum report latency from `fim_classificacao` is 1 (ENVIA) + 4×(2 + tx time) cycles.

## Configuration
- `CIRCUITO_UC_DB_ESTADO_EN`:
  - Defined: adds output port `db_estado` [3:0] carrying the raw state encoding.
  - Undefined: the port does not exist and the behaviour is otherwise identical.

## Structure
- `circuito_projeto_pkg` holds:
  - the 4-bit state encoding, 15 states: INICIAL=0 through ERRO=14;
  - class constants CLASSE_BAIXA=3'b001 and CLASSE_ALTA=3'b100;
  - the default `MAX_DESCARTES`.
- The discard counter uses one instance of the existing `contador_m` (M=`MAX_DESCARTES`, N=3). No other sub-modules.

## Test plan
- Reset then `ligar`=1, `fim_1s` at cycle 10 → PREPARA strobes `zera` once, `mensurar` pulses 1 cycle after `fim_1s`.
- Classification 3'b001, no discard, four `fim_carater` with `fim_mensagem` on the 4th `muda` → exactly 4 `envia` pulses, then `pronto` and `liga_buzzer_baixa` in the same cycle.
- Classification 3'b100 → `liga_buzzer_alta`. Code 3'b010 → `desliga_buzzers`.
- `descartar_medida`=1 three times with MAX_DESCARTES=3 → `mensurar` pulses 3 times total, then `erro`=1. Dropping `ligar` → INICIAL with `erro`=0.
- Two discards then a valid measure, followed by three more discards → no ERRO on the first run (counter cleared in ENVIA), ERRO on the third discard after it.
- `ligar`=0 in the same cycle as `fim_2s` → DESLIGA (`desliga_buzzers`+`zera_vlv` for 1 cycle), no `mensurar`. `reset` during AGUARDA_CARATER → all outputs 0 the next cycle.
